// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bundle: instruction-memory request/response, redirect input and decoder-facing output.
// master is the fetch unit's view; slave is the memory/decoder/branch-resolution side.
interface instr_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// PC owner and instruction prefetch buffer feeding the control decoder.
// Optional macro IFU_BYPASS_EN forwards a response straight to the outputs when the buffer is empty.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_unit_if.master bus
);
    localparam int            CW        = $clog2(FIFO_DEPTH + 1);
    localparam int            PW        = $clog2(FIFO_DEPTH);
    localparam logic [CW:0]   DEPTH_SUM = (CW + 1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_IDX  = PW'(FIFO_DEPTH - 1);
    localparam logic [31:0]   PC_MASK   = 32'hFFFF_FFFC;

    logic [31:0]   pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] fifo_count;
    logic [PW-1:0] fifo_rd;
    logic [PW-1:0] fifo_wr;
    logic [31:0]   fifo_data [FIFO_DEPTH];
    logic [31:0]   fifo_pc   [FIFO_DEPTH];
    logic [PW-1:0] pcq_rd;
    logic [PW-1:0] pcq_wr;
    logic [31:0]   pcq_addr  [FIFO_DEPTH];

    logic req_fire;
    logic rsp_drop;
    logic rsp_keep;
    logic fifo_valid;
    logic fifo_push;
    logic fifo_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + PW'(1);
    endfunction

    // Credit counts both in-flight and buffered words so a returning response always has a slot.
    assign bus.imem_req_valid = !rst && (({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_SUM);
    assign bus.imem_req_addr  = pc;

    assign req_fire   = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_drop   = bus.imem_rsp_valid && (drop_cnt != '0);
    assign rsp_keep   = !rst && bus.imem_rsp_valid && (drop_cnt == '0) && !bus.redirect_valid;
    assign fifo_valid = (fifo_count != '0);
    assign fifo_pop   = fifo_valid && bus.inst_ready;

    always_comb begin
        outstanding_next = outstanding + CW'(req_fire) - CW'(bus.imem_rsp_valid);
    end

`ifdef IFU_BYPASS_EN
    logic bypass_hit;

    assign bypass_hit     = rsp_keep && !fifo_valid;
    assign fifo_push      = rsp_keep && !(bypass_hit && bus.inst_ready);
    assign bus.inst_valid = fifo_valid || bypass_hit;
    assign bus.inst_data  = fifo_valid ? fifo_data[fifo_rd] :
                            (bypass_hit ? bus.imem_rsp_data : NOP_WORD);
    assign bus.inst_pc    = fifo_valid ? fifo_pc[fifo_rd] :
                            (bypass_hit ? pcq_addr[pcq_rd] : 32'd0);
`else
    assign fifo_push      = rsp_keep;
    assign bus.inst_valid = fifo_valid;
    assign bus.inst_data  = fifo_valid ? fifo_data[fifo_rd] : NOP_WORD;
    assign bus.inst_pc    = fifo_valid ? fifo_pc[fifo_rd] : 32'd0;
`endif

    // Redirect wins over normal PC/FIFO updates; every fetch still in flight afterwards is stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC & PC_MASK;
            outstanding <= '0;
            drop_cnt    <= '0;
            fifo_count  <= '0;
            fifo_rd     <= '0;
            fifo_wr     <= '0;
            pcq_rd      <= '0;
            pcq_wr      <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (req_fire) begin
                pcq_wr <= ptr_inc(pcq_wr);
            end
            if (bus.imem_rsp_valid) begin
                pcq_rd <= ptr_inc(pcq_rd);
            end
            if (bus.redirect_valid) begin
                pc         <= bus.redirect_pc & PC_MASK;
                drop_cnt   <= outstanding_next;
                fifo_count <= '0;
                fifo_rd    <= '0;
                fifo_wr    <= '0;
            end else begin
                if (req_fire) begin
                    pc <= pc + 32'd4;
                end
                if (rsp_drop) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
                if (fifo_push) begin
                    fifo_wr <= ptr_inc(fifo_wr);
                end
                if (fifo_pop) begin
                    fifo_rd <= ptr_inc(fifo_rd);
                end
                fifo_count <= fifo_count + CW'(fifo_push) - CW'(fifo_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            pcq_addr[pcq_wr] <= pc;
        end
        if (fifo_push) begin
            fifo_data[fifo_wr] <= bus.imem_rsp_data;
            fifo_pc[fifo_wr]   <= pcq_addr[pcq_rd];
        end
    end
endmodule
